// File: rtl/sudoku_pkg.sv
// Shared constants, state encoding and payload types for the solver-side puzzle bus port.
package sudoku_pkg;

  localparam int unsigned CELL_W    = 4;
  localparam int unsigned N_CELLS   = 81;
  localparam int unsigned GRID_W    = CELL_W * N_CELLS;
  localparam int unsigned MAX_DIGIT = 9;
  localparam int unsigned CYC_W     = 32;

  typedef logic [GRID_W-1:0] grid_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_WAIT_LOAD,
    S_PRESENT,
    S_SOLVING,
    S_SETUP,
    S_STROBE,
    S_HOLD
  } state_e;

  // Grid and verdict presented on the bus during the drive window.
  typedef struct packed {
    logic  solved;
    grid_t grid;
  } result_t;

  // Width of a down-counter able to hold the largest of the phase lengths.
  function automatic int unsigned phase_cnt_w(input int unsigned a, input int unsigned b,
                                              input int unsigned c);
    int unsigned m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return (m < 2) ? 1 : $clog2(m + 1);
  endfunction

endpackage

// File: rtl/sudoku_cell_check.sv
// Flags a grid containing any cell whose value exceeds the largest legal digit.
module sudoku_cell_check
  import sudoku_pkg::*;
(
  input  logic [GRID_W-1:0] grid,
  output logic              bad
);

  always_comb begin
    bad = 1'b0;
    for (int unsigned i = 0; i < N_CELLS; i++) begin
      if (grid[i*CELL_W +: CELL_W] > CELL_W'(MAX_DIGIT)) bad = 1'b1;
    end
  end

endmodule

// File: rtl/sudoku_io_port.sv
// Solver-side puzzle bus endpoint: requests and captures puzzles, hands them to the core,
// and drives the result back onto the shared bus around a solution/give_up strobe.
module sudoku_io_port
  import sudoku_pkg::*;
#(
  parameter int unsigned LOAD_LAT = 2,
  parameter int unsigned SETUP    = 1,
  parameter int unsigned HOLD     = 2,
  parameter int unsigned TIMEOUT  = 1000000
) (
  input  logic              clk,
  input  logic              rst_n,
  inout  wire  [GRID_W-1:0] puzzle_io,
  output logic              puzzle_oe,
  output logic              next_puzzle,
  output logic              solution,
  output logic              give_up,
  output logic [GRID_W-1:0] core_grid,
  output logic              core_valid,
  input  logic              core_ready,
  output logic              core_abort,
  input  logic [GRID_W-1:0] res_grid,
  input  logic              res_solved,
  input  logic              res_valid,
  output logic              res_ready,
  output logic [GRID_W-1:0] extra_out
);

  localparam int unsigned WAIT_W = phase_cnt_w(LOAD_LAT, SETUP, HOLD);

  state_e              state_q, state_d;
  logic [WAIT_W-1:0]   wait_q, wait_d;
  logic [CYC_W-1:0]    cyc_q, cyc_d;
  grid_t               grid_q, grid_d;
  result_t             res_q, res_d;
  logic                oe_q, oe_d;
  logic                np_q, np_d;
  logic                sol_q, sol_d;
  logic                gu_q, gu_d;
  logic                cv_q, cv_d;
  logic                ab_q, ab_d;
  logic                rr_q, rr_d;
  logic                load_bad;

  sudoku_cell_check u_cell_check (
    .grid (puzzle_io),
    .bad  (load_bad)
  );

  // Next state, counters and data registers.
  always_comb begin
    state_d = state_q;
    wait_d  = wait_q;
    cyc_d   = cyc_q;
    grid_d  = grid_q;
    res_d   = res_q;
    ab_d    = 1'b0;

    unique case (state_q)
      S_IDLE: state_d = S_REQ;
      S_REQ: begin
        wait_d  = WAIT_W'(LOAD_LAT - 1);
        state_d = S_WAIT_LOAD;
      end
      S_WAIT_LOAD: begin
        if (wait_q == '0) begin
          grid_d = puzzle_io;
          if (load_bad) begin
            res_d.grid   = puzzle_io;
            res_d.solved = 1'b0;
            wait_d       = WAIT_W'(SETUP - 1);
            state_d      = S_SETUP;
          end else begin
            state_d = S_PRESENT;
          end
        end else begin
          wait_d = wait_q - WAIT_W'(1);
        end
      end
      S_PRESENT: begin
        if (core_ready) begin
          cyc_d   = '0;
          state_d = S_SOLVING;
        end
      end
      S_SOLVING: begin
        cyc_d = cyc_q + CYC_W'(1);
        // A result arriving on the timeout cycle takes precedence over the abort.
        if (res_valid) begin
          res_d.grid   = res_grid;
          res_d.solved = res_solved;
          wait_d       = WAIT_W'(SETUP - 1);
          state_d      = S_SETUP;
        end else if (cyc_q == CYC_W'(TIMEOUT - 1)) begin
          ab_d         = 1'b1;
          res_d.grid   = grid_q;
          res_d.solved = 1'b0;
          wait_d       = WAIT_W'(SETUP - 1);
          state_d      = S_SETUP;
        end
      end
      S_SETUP: begin
        if (wait_q == '0) state_d = S_STROBE;
        else              wait_d  = wait_q - WAIT_W'(1);
      end
      S_STROBE: begin
        wait_d  = WAIT_W'(HOLD - 1);
        state_d = S_HOLD;
      end
      S_HOLD: begin
        if (wait_q == '0) state_d = S_REQ;
        else              wait_d  = wait_q - WAIT_W'(1);
      end
      default: state_d = S_IDLE;
    endcase

    // Outputs are decoded from the next state so the flops line up with the state register.
    np_d  = (state_d == S_REQ);
    cv_d  = (state_d == S_PRESENT);
    rr_d  = (state_d == S_SOLVING);
    oe_d  = (state_d == S_SETUP) || (state_d == S_STROBE) || (state_d == S_HOLD);
    sol_d = (state_d == S_STROBE) && res_q.solved;
    gu_d  = (state_d == S_STROBE) && !res_q.solved;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      wait_q  <= '0;
      cyc_q   <= '0;
      grid_q  <= '0;
      res_q   <= '0;
      oe_q    <= 1'b0;
      np_q    <= 1'b0;
      sol_q   <= 1'b0;
      gu_q    <= 1'b0;
      cv_q    <= 1'b0;
      ab_q    <= 1'b0;
      rr_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      cyc_q   <= cyc_d;
      grid_q  <= grid_d;
      res_q   <= res_d;
      oe_q    <= oe_d;
      np_q    <= np_d;
      sol_q   <= sol_d;
      gu_q    <= gu_d;
      cv_q    <= cv_d;
      ab_q    <= ab_d;
      rr_q    <= rr_d;
    end
  end

  assign puzzle_io   = oe_q ? res_q.grid : {GRID_W{1'bz}};
  assign puzzle_oe   = oe_q;
  assign next_puzzle = np_q;
  assign solution    = sol_q;
  assign give_up     = gu_q;
  assign core_valid  = cv_q;
  assign core_abort  = ab_q;
  assign res_ready   = rr_q;
  assign core_grid   = grid_q;
  assign extra_out   = grid_q;

endmodule

// File: tb/tb_sudoku_io_port.sv
// Self-checking bench for sudoku_io_port: directed scenario table plus randomized transactions.
module tb_sudoku_io_port;
  import sudoku_pkg::*;

  localparam int unsigned LL = 2;
  localparam int unsigned SU = 1;
  localparam int unsigned HO = 2;
  localparam int unsigned TO = 20;

  typedef struct {
    bit          bad;
    int unsigned bad_cell;
    logic [3:0]  bad_val;
    int unsigned rdy_dly;
    int unsigned lat;
    bit          solved;
    bit          exp_sol;
    bit          exp_abort;
  } scen_t;

  logic              clk;
  logic              rst_n;
  logic              tb_oe;
  grid_t             tb_bus;
  wire  [GRID_W-1:0] puzzle_io;
  logic              puzzle_oe, next_puzzle, solution, give_up;
  logic [GRID_W-1:0] core_grid, extra_out, res_grid;
  logic              core_valid, core_ready, core_abort;
  logic              res_solved, res_valid, res_ready;

  int checks   = 0;
  int failures = 0;

  assign puzzle_io = tb_oe ? tb_bus : {GRID_W{1'bz}};

  sudoku_io_port #(
    .LOAD_LAT (LL),
    .SETUP    (SU),
    .HOLD     (HO),
    .TIMEOUT  (TO)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .puzzle_io   (puzzle_io),
    .puzzle_oe   (puzzle_oe),
    .next_puzzle (next_puzzle),
    .solution    (solution),
    .give_up     (give_up),
    .core_grid   (core_grid),
    .core_valid  (core_valid),
    .core_ready  (core_ready),
    .core_abort  (core_abort),
    .res_grid    (res_grid),
    .res_solved  (res_solved),
    .res_valid   (res_valid),
    .res_ready   (res_ready),
    .extra_out   (extra_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk_grid(input string name, input logic [GRID_W-1:0] act,
                          input logic [GRID_W-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%h want=%h", name, act, exp);
    end
  endtask

  // Control vector order: next_puzzle core_valid res_ready core_abort puzzle_oe solution give_up
  task automatic chk_ctl(input string name, input int unsigned cyc, input logic [6:0] act,
                         input logic [6:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s cycle=%0d got=%b want=%b", name, cyc, act, exp);
    end
  endtask

  function automatic grid_t rand_grid(input int unsigned lo, input int unsigned hi);
    grid_t g;
    for (int i = 0; i < int'(N_CELLS); i++) g[i*CELL_W +: CELL_W] = CELL_W'($urandom_range(hi, lo));
    return g;
  endfunction

  // Reference outcome: bad grid gives up with the puzzle, late core times out, else core verdict.
  function automatic scen_t model(input scen_t s);
    scen_t r;
    r = s;
    r.exp_abort = !s.bad && (s.lat > TO);
    r.exp_sol   = !s.bad && (s.lat <= TO) && s.solved;
    return r;
  endfunction

  function automatic logic [6:0] ctl_now();
    return {next_puzzle, core_valid, res_ready, core_abort, puzzle_oe, solution, give_up};
  endfunction

  // One full request-to-release transaction; cycle 0 is the expected next_puzzle cycle.
  task automatic run_txn(input scen_t s, input bit rst_in_hold);
    grid_t       pz, rg, junk, exp_bus;
    int unsigned v, x, os, c_end, rr_end;
    logic [6:0]  exp;
    pz   = rand_grid(0, 9);
    rg   = rand_grid(1, 9);
    junk = rand_grid(0, 9);
    if (s.bad) pz[s.bad_cell*CELL_W +: CELL_W] = s.bad_val;
    v = LL + 1;
    x = v + s.rdy_dly;
    if (s.bad)            os = LL + 1;
    else if (s.exp_abort) os = x + TO + 1;
    else                  os = x + s.lat + 1;
    rr_end  = s.exp_abort ? x + TO : x + s.lat;
    c_end   = os + SU + 1 + HO;
    exp_bus = (s.bad || s.exp_abort) ? pz : rg;

    for (int unsigned c = 0; c < c_end; c++) begin
      @(posedge clk);
      #1;
      tb_oe      = (c >= 1) && (c <= LL);
      tb_bus     = (c == LL) ? pz : junk;
      core_ready = !s.bad && (c == x);
      res_valid  = !s.bad && (c == x + s.lat);
      res_solved = s.solved;
      res_grid   = res_valid ? rg : rand_grid(0, 15);

      if (rst_in_hold && (c == os + SU + 1)) begin
        #2 rst_n = 1'b0;
        #1 chk_ctl("rst_async_ctl", c, ctl_now(), 7'b0);
        tb_bus = rand_grid(0, 9);
        tb_oe  = 1'b1;
        #1 chk_grid("rst_bus_released", puzzle_io, tb_bus);
        @(negedge clk);
        chk_grid("rst_extra_out", extra_out, '0);
        chk_grid("rst_core_grid", core_grid, '0);
        chk_ctl("rst_held_ctl", c, ctl_now(), 7'b0);
        tb_oe = 1'b0;
        rst_n = 1'b1;
        return;
      end

      @(negedge clk);
      exp[6] = (c == 0);
      exp[5] = !s.bad && (c >= v) && (c <= x);
      exp[4] = !s.bad && (c > x) && (c <= rr_end);
      exp[3] = s.exp_abort && (c == x + TO + 1);
      exp[2] = (c >= os) && (c < os + SU + 1 + HO);
      exp[1] = (c == os + SU) && s.exp_sol;
      exp[0] = (c == os + SU) && !s.exp_sol;
      chk_ctl("ctl", c, ctl_now(), exp);
      if (exp[2]) chk_grid("bus_out", puzzle_io, exp_bus);
      if ((c >= 1) && (c <= LL)) chk_grid("bus_released", puzzle_io, tb_bus);
      if (c > LL) begin
        chk_grid("core_grid", core_grid, pz);
        chk_grid("extra_out", extra_out, pz);
      end
    end
    tb_oe = 1'b0;
  endtask

  scen_t tbl [10];
  scen_t rs;

  initial begin
    tbl[0] = '{bad:0, bad_cell:0,  bad_val:4'h0, rdy_dly:0, lat:10,   solved:1, exp_sol:1, exp_abort:0};
    tbl[1] = '{bad:0, bad_cell:0,  bad_val:4'h0, rdy_dly:0, lat:10,   solved:0, exp_sol:0, exp_abort:0};
    tbl[2] = '{bad:0, bad_cell:0,  bad_val:4'h0, rdy_dly:0, lat:1000, solved:1, exp_sol:0, exp_abort:1};
    tbl[3] = '{bad:1, bad_cell:40, bad_val:4'hC, rdy_dly:0, lat:5,    solved:1, exp_sol:0, exp_abort:0};
    tbl[4] = '{bad:0, bad_cell:0,  bad_val:4'h0, rdy_dly:1, lat:20,   solved:1, exp_sol:1, exp_abort:0};
    tbl[5] = '{bad:0, bad_cell:0,  bad_val:4'h0, rdy_dly:2, lat:1,    solved:1, exp_sol:1, exp_abort:0};
    tbl[6] = '{bad:0, bad_cell:0,  bad_val:4'h0, rdy_dly:0, lat:21,   solved:1, exp_sol:0, exp_abort:1};
    tbl[7] = '{bad:1, bad_cell:80, bad_val:4'hA, rdy_dly:0, lat:5,    solved:1, exp_sol:0, exp_abort:0};
    tbl[8] = '{bad:1, bad_cell:0,  bad_val:4'hF, rdy_dly:0, lat:5,    solved:0, exp_sol:0, exp_abort:0};
    tbl[9] = '{bad:0, bad_cell:0,  bad_val:4'h0, rdy_dly:3, lat:19,   solved:0, exp_sol:0, exp_abort:0};

    rst_n      = 1'b0;
    tb_oe      = 1'b0;
    tb_bus     = '0;
    core_ready = 1'b0;
    res_valid  = 1'b0;
    res_solved = 1'b0;
    res_grid   = '0;

    repeat (3) @(negedge clk);
    chk_ctl("reset_ctl", 0, ctl_now(), 7'b0);
    chk_grid("reset_core_grid", core_grid, '0);
    chk_grid("reset_extra_out", extra_out, '0);
    tb_bus = rand_grid(0, 9);
    tb_oe  = 1'b1;
    #1 chk_grid("reset_bus_released", puzzle_io, tb_bus);
    tb_oe = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 10; i++) run_txn(tbl[i], 1'b0);

    // Reset in the middle of the hold window, then a clean restart from idle.
    run_txn(tbl[0], 1'b1);
    run_txn(tbl[1], 1'b0);

    for (int i = 0; i < 40; i++) begin
      rs.bad      = ($urandom_range(5, 0) == 0);
      rs.bad_cell = $urandom_range(80, 0);
      rs.bad_val  = 4'($urandom_range(15, 10));
      rs.rdy_dly  = $urandom_range(3, 0);
      rs.lat      = $urandom_range(24, 1);
      rs.solved   = 1'($urandom_range(1, 0));
      rs.exp_sol  = 1'b0;
      rs.exp_abort = 1'b0;
      run_txn(model(rs), 1'b0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
